// File: rtl/jtcop_pal_dma.sv
// Palette copy controller: copies the CPU shadow palette into the video palette RAM.
// It copies one word per clock and only starts while vertical blank (LVBL low) is active.
// Optional build macro: JTCOP_PALDMA_VBPAUSE_EN.
//   When it is defined, the copy pauses whenever LVBL goes high during COPY.
//   The copy then resumes at the next blank, so the palette never changes during active video.
// Without the macro, LVBL only gates the start of a transfer.
module jtcop_pal_dma #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic          dma_req,
    output logic [AW-1:0] shd_addr,
    input  logic [DW-1:0] shd_dout,
    output logic [AW-1:0] pal_addr,
    output logic [DW-1:0] pal_din,
    output logic          pal_we,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VB,
        COPY,
        DRAIN
    } state_t;

    state_t        state, state_nx;
    logic [AW:0]   rd_cnt, rd_cnt_nx;
    logic          pending, pending_nx;
    logic          pal_we_nx;
    logic [AW-1:0] pal_addr_nx;
    logic          done_nx;
    logic          rd_en;

    // Read enable inside COPY: either free-running or gated by blank
`ifdef JTCOP_PALDMA_VBPAUSE_EN
    assign rd_en = ~LVBL;
`else
    assign rd_en = 1'b1;
`endif

    // Shadow address follows the read counter.
    // The counter is frozen outside active reads, so the address holds its last value.
    assign shd_addr = rd_cnt[AW-1:0];
    // Synchronous-read data lines up with the registered write strobe
    assign pal_din  = shd_dout;
    // Busy covers the done cycle too, so a back-to-back request shows no low gap
    assign busy     = (state != IDLE) || done;

    // Next-state logic, read counter and write strobe generation
    always_comb begin
        state_nx    = state;
        rd_cnt_nx   = rd_cnt;
        pending_nx  = pending;
        pal_we_nx   = 1'b0;
        pal_addr_nx = pal_addr;
        done_nx     = 1'b0;

        // Only one extra transfer can be queued
        if (dma_req && state != IDLE) pending_nx = 1'b1;

        case (state)
            IDLE: begin
                if (dma_req) state_nx = WAIT_VB;
            end
            WAIT_VB: begin
                if (!LVBL) begin
                    state_nx  = COPY;
                    rd_cnt_nx = '0;
                end
            end
            COPY: begin
                if (rd_en) begin
                    // Read issued this cycle is written on the next one
                    pal_we_nx   = 1'b1;
                    pal_addr_nx = rd_cnt[AW-1:0];
                    rd_cnt_nx   = rd_cnt + 1'b1;
                    if (rd_cnt_nx[AW]) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                done_nx = 1'b1;
                if (pending || dma_req) begin
                    state_nx   = WAIT_VB;
                    pending_nx = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; reset abandons any partial copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            pending  <= 1'b0;
            pal_we   <= 1'b0;
            pal_addr <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            rd_cnt   <= rd_cnt_nx;
            pending  <= pending_nx;
            pal_we   <= pal_we_nx;
            pal_addr <= pal_addr_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_jtcop_pal_dma.sv
// Bench for jtcop_pal_dma.
// The stimulus process pushes the expected palette writes into a queue.
// A separate monitor pops one entry and compares it on every pal_we.
module tb_jtcop_pal_dma;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          LVBL;
    logic          dma_req;
    logic [AW-1:0] shd_addr;
    logic [DW-1:0] shd_dout;
    logic [AW-1:0] pal_addr;
    logic [DW-1:0] pal_din;
    logic          pal_we;
    logic          busy;
    logic          done;

    logic [DW-1:0] key;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  done_cnt   = 0;
    int  wr_cnt     = 0;

    jtcop_pal_dma #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .LVBL     (LVBL),
        .dma_req  (dma_req),
        .shd_addr (shd_addr),
        .shd_dout (shd_dout),
        .pal_addr (pal_addr),
        .pal_din  (pal_din),
        .pal_we   (pal_we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Shadow RAM model: one-cycle synchronous read of addr ^ key
    always @(posedge clk) shd_dout <= {{(DW-AW){1'b0}}, shd_addr} ^ key;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Monitor: scoreboard pops on each write and checks done placement
    initial begin
        logic          prev_we;
        logic [AW-1:0] prev_addr;
        wr_t           e;
        prev_we   = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (pal_we === 1'b1) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_write: pal_addr=%0d pal_din=0x%0h, none expected",
                                 pal_addr, pal_din);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", {22'd0, pal_addr}, {22'd0, e.a});
                        chk("wr_data", {16'd0, pal_din}, {16'd0, e.d});
                    end
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    chk("done_after_last_write", {20'd0, prev_we, pal_we, prev_addr},
                        {20'd0, 1'b1, 1'b0, 10'(N - 1)});
                end
                prev_we   = pal_we;
                prev_addr = pal_addr;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_xfer();
        wr_t e;
        for (int i = 0; i < N; i++) begin
            e.a = AW'(i);
            e.d = DW'(i) ^ key;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_req(input string nm);
        dma_req = 1'b1;
        tick(1);
        dma_req = 1'b0;
        chk(nm, {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            tick(1);
            k++;
        end
        chk("done_count", done_cnt, target);
    endtask

    task automatic wait_writes(input int base, input int n, input int budget);
        int k;
        k = 0;
        while (wr_cnt - base < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("write_progress", wr_cnt - base, n);
    endtask

    // Stimulus
    initial begin
        int w0;
        int d0;
        int low_cnt;
        int k;

        dma_req = 1'b0;
        LVBL    = 1'b0;
        key     = 16'hA5A5;
        rst     = 1'b0;
        #1 rst  = 1'b1;
        tick(3);

        // Reset state
        chk("rst_pal_we", {31'd0, pal_we}, 32'd0);
        chk("rst_pal_addr", {22'd0, pal_addr}, 32'd0);
        chk("rst_shd_addr", {22'd0, shd_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Basic transfer inside blank
        push_xfer();
        pulse_req("busy_after_req");
        wait_done(1, N + 100);
        chk("queue_empty_basic", exp_q.size(), 0);
        tick(2);
        chk("busy_low_after_done", {31'd0, busy}, 32'd0);

        // Wait for blank
        key  = 16'h3C3C;
        LVBL = 1'b1;
        tick(1);
        push_xfer();
        w0 = wr_cnt;
        pulse_req("busy_wait_vb");
        tick(499);
        chk("no_write_in_active", wr_cnt - w0, 0);
        LVBL = 1'b0;
        @(negedge clk);
        chk("vb_fall_c0_we", {31'd0, pal_we}, 32'd0);
        @(negedge clk);
        chk("vb_fall_c1_we", {31'd0, pal_we}, 32'd0);
        @(negedge clk);
        chk("vb_fall_c2_we", {31'd0, pal_we}, 32'd1);
        chk("vb_fall_c2_addr", {22'd0, pal_addr}, 32'd0);
        wait_done(2, N + 100);
        chk("queue_empty_wait", exp_q.size(), 0);
        tick(2);

        // Blank ends mid-copy
        key = 16'h0F0F;
        push_xfer();
        w0 = wr_cnt;
        pulse_req("busy_midcopy");
        wait_writes(w0, 300, 400);
        LVBL = 1'b1;
`ifdef JTCOP_PALDMA_VBPAUSE_EN
        tick(2000);
        chk("paused_writes", wr_cnt - w0, 301);
        chk("paused_busy", {31'd0, busy}, 32'd1);
        chk("paused_no_done", done_cnt, 2);
        LVBL = 1'b0;
        wait_done(3, N + 100);
`else
        wait_done(3, N + 100);
        LVBL = 1'b0;
`endif
        chk("midcopy_total_writes", wr_cnt - w0, N);
        chk("queue_empty_midcopy", exp_q.size(), 0);
        tick(2);

        // Pending request: two extra requests collapse into one more transfer
        key = 16'h5A5A;
        push_xfer();
        w0 = wr_cnt;
        pulse_req("busy_pend");
        wait_writes(w0, 100, 200);
        push_xfer();
        pulse_req("busy_second_req");
        tick(50);
        pulse_req("busy_third_req");
        wait_done(5, 2 * N + 200);
        tick(20);
        chk("pend_done_total", done_cnt, 5);
        chk("pend_busy_idle", {31'd0, busy}, 32'd0);
        chk("pend_total_writes", wr_cnt - w0, 2 * N);
        chk("queue_empty_pend", exp_q.size(), 0);

        // Reset mid-copy
        key = 16'h1234;
        push_xfer();
        w0 = wr_cnt;
        pulse_req("busy_rst");
        wait_writes(w0, 600, 700);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_pal_we", {31'd0, pal_we}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        d0  = done_cnt;
        w0  = wr_cnt;
        tick(N + 100);
        chk("rst_no_writes", wr_cnt - w0, 0);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_busy_idle", {31'd0, busy}, 32'd0);

        // Request coincident with done
        key = 16'hABCD;
        push_xfer();
        d0 = done_cnt;
        pulse_req("busy_req_on_done");
        k = 0;
        while (done !== 1'b1 && k < N + 100) begin
            tick(1);
            k++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        push_xfer();
        dma_req = 1'b1;
        tick(1);
        dma_req = 1'b0;
        low_cnt = 0;
        k = 0;
        while (done_cnt < d0 + 2 && k < N + 100) begin
            if (busy !== 1'b1) low_cnt++;
            tick(1);
            k++;
        end
        chk("req_on_done_busy_gap", low_cnt, 0);
        chk("req_on_done_dones", done_cnt - d0, 2);
        chk("queue_empty_req_on_done", exp_q.size(), 0);
        tick(3);
        chk("final_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Safety net against a hang
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
        $fatal(1);
    end

endmodule
